// File: rtl/mips_mem_sequencer.sv
// Multi-cycle sequencer that serialises a Harvard core's fetch and data accesses
// onto one Avalon-style memory port and strobes the core's clock enable per instruction.
module mips_mem_sequencer #(
    parameter int TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_active,
    input  logic [31:0] instr_address,
    input  logic        instr_read,
    output logic [31:0] instr_readdata,
    input  logic [31:0] data_address,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [31:0] data_writedata,
    input  logic [3:0]  byte_enable,
    output logic [31:0] data_readdata,
    output logic        cpu_clk_enable,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic [31:0] mem_readdata,
    input  logic        mem_waitrequest,
    output logic        bus_error,
    output logic        proto_error,
    output logic [31:0] instr_retired
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_COMMIT = 3'd4;
    localparam logic [2:0] S_ERROR  = 3'd5;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] wait_q, wait_d;
    logic [31:0]   ird_q, ird_d;
    logic [31:0]   drd_q, drd_d;
    logic [31:0]   retired_q, retired_d;
    logic          berr_q, berr_d;
    logic          perr_q, perr_d;

    // A simultaneous read and write request is serviced as a write only.
    logic data_is_write, data_is_read;
    assign data_is_write = data_write;
    assign data_is_read  = data_read & ~data_write;

    // The fetch request is implicit and the low address bits are dropped on the bus.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, instr_read, instr_address[1:0], data_address[1:0]};

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        ird_d     = ird_q;
        drd_d     = drd_q;
        retired_d = retired_q;
        berr_d    = berr_q;
        perr_d    = perr_q;
        case (state_q)
            S_IDLE: begin
                if (cpu_active) begin
                    state_d = S_FETCH;
                    wait_d  = '0;
                end
            end
            S_FETCH: begin
                if (!mem_waitrequest) begin
                    ird_d   = mem_readdata;
                    state_d = S_DECODE;
                end else if (wait_q == WAIT_LAST) begin
                    berr_d  = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_DECODE: begin
                if (data_read || data_write) begin
                    state_d = S_DATA;
                    wait_d  = '0;
                    if (data_read && data_write) begin
                        perr_d = 1'b1;
                    end
                end else begin
                    state_d = S_COMMIT;
                end
            end
            S_DATA: begin
                if (!mem_waitrequest) begin
                    if (data_is_read) begin
                        drd_d = mem_readdata;
                    end
                    state_d = S_COMMIT;
                end else if (wait_q == WAIT_LAST) begin
                    berr_d  = 1'b1;
                    state_d = S_ERROR;
                end else begin
                    wait_d = wait_q + CW'(1);
                end
            end
            S_COMMIT: begin
                retired_d = retired_q + 32'd1;
                state_d   = S_IDLE;
            end
            S_ERROR: begin
                state_d = S_ERROR;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            wait_q    <= '0;
            ird_q     <= '0;
            drd_q     <= '0;
            retired_q <= '0;
            berr_q    <= 1'b0;
            perr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            ird_q     <= ird_d;
            drd_q     <= drd_d;
            retired_q <= retired_d;
            berr_q    <= berr_d;
            perr_q    <= perr_d;
        end
    end

    // Bus strobes decode from state only, so they never react to waitrequest.
    always_comb begin
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        case (state_q)
            S_FETCH: begin
                mem_address    = {instr_address[31:2], 2'b00};
                mem_read       = 1'b1;
                mem_byteenable = 4'hF;
            end
            S_DATA: begin
                mem_address    = {data_address[31:2], 2'b00};
                mem_read       = data_is_read;
                mem_write      = data_is_write;
                mem_writedata  = data_writedata;
                mem_byteenable = byte_enable;
            end
            default: begin
            end
        endcase
    end

    assign cpu_clk_enable = (state_q == S_COMMIT);
    assign instr_readdata = ird_q;
    assign data_readdata  = drd_q;
    assign instr_retired  = retired_q;
    assign bus_error      = berr_q;
    assign proto_error    = perr_q;

endmodule

// File: tb/tb_mips_mem_sequencer.sv
// Scoreboard bench for mips_mem_sequencer: directed instructions push expected bus
// transfers and commits; a negedge monitor pops and compares them as they appear.
module tb_mips_mem_sequencer;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        cpu_active;
    logic [31:0] instr_address;
    logic        instr_read;
    logic [31:0] instr_readdata;
    logic [31:0] data_address;
    logic        data_read;
    logic        data_write;
    logic [31:0] data_writedata;
    logic [3:0]  byte_enable;
    logic [31:0] data_readdata;
    logic        cpu_clk_enable;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic [3:0]  mem_byteenable;
    logic [31:0] mem_readdata;
    logic        mem_waitrequest;
    logic        bus_error;
    logic        proto_error;
    logic [31:0] instr_retired;

    always #5 clk = ~clk;

    mips_mem_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .cpu_active(cpu_active),
        .instr_address(instr_address), .instr_read(instr_read), .instr_readdata(instr_readdata),
        .data_address(data_address), .data_read(data_read), .data_write(data_write),
        .data_writedata(data_writedata), .byte_enable(byte_enable), .data_readdata(data_readdata),
        .cpu_clk_enable(cpu_clk_enable), .mem_address(mem_address), .mem_read(mem_read),
        .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest),
        .bus_error(bus_error), .proto_error(proto_error), .instr_retired(instr_retired)
    );

    // kind: 0 bus read, 1 bus write, 2 commit
    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [31:0] ird;
        logic [31:0] drd;
        int          rel;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc_now = 0;
    int          start_cyc = 0;
    int          fetch_wait = 0;
    int          data_wait = 0;
    logic [31:0] fetch_word = '0;
    logic [31:0] load_word = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push_bus(input int kind, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wdata);
        exp_t e;
        e.kind = kind; e.addr = addr; e.be = be; e.wdata = wdata;
        e.ird = '0; e.drd = '0; e.rel = 0;
        exp_q.push_back(e);
    endtask

    task automatic push_commit(input logic [31:0] ird, input logic [31:0] drd, input int rel);
        exp_t e;
        e.kind = 2; e.addr = '0; e.be = '0; e.wdata = '0;
        e.ird = ird; e.drd = drd; e.rel = rel;
        exp_q.push_back(e);
    endtask

    always @(posedge clk) cyc_now = cyc_now + 1;

    // Memory responder: segment 1 of an instruction is the fetch, segment 2 the data access.
    initial begin
        int seg = 0;
        int rc = 0;
        bit prev_req = 0;
        bit req;
        mem_waitrequest = 1'b0;
        mem_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                seg = 0; rc = 0; prev_req = 0; mem_waitrequest = 1'b0;
            end else begin
                req = mem_read | mem_write;
                if (req && !prev_req) begin
                    seg++;
                    rc = 0;
                end
                if (req) begin
                    mem_waitrequest = (rc < ((seg == 1) ? fetch_wait : data_wait));
                    mem_readdata = (seg == 1) ? fetch_word : load_word;
                    rc++;
                end else begin
                    mem_waitrequest = 1'b0;
                end
                prev_req = req;
                if (cpu_clk_enable) seg = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                check("rw_exclusive", {31'b0, mem_read & mem_write}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL bus_unexpected: transfer at %h with nothing expected", mem_address);
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("bus  %s addr=%h be=%h wdata=%h", mem_write ? "WR" : "RD",
                             mem_address, mem_byteenable, mem_writedata);
                    check("bus_kind", mem_write ? 32'd1 : 32'd0, 32'(mon_e.kind));
                    check("bus_addr", mem_address, mon_e.addr);
                    check("bus_be", {28'b0, mem_byteenable}, {28'b0, mon_e.be});
                    if (mon_e.kind == 1) check("bus_wdata", mem_writedata, mon_e.wdata);
                end
            end
            if (cpu_clk_enable) begin
                if (exp_q.size() == 0) begin
                    n_cmp++; n_fail++;
                    $display("FAIL commit_unexpected: commit strobe with nothing expected");
                end else begin
                    mon_e = exp_q.pop_front();
                    $display("commit ird=%h drd=%h cycle=%0d", instr_readdata, data_readdata,
                             cyc_now - start_cyc + 1);
                    check("commit_kind", 32'(mon_e.kind), 32'd2);
                    check("commit_ird", instr_readdata, mon_e.ird);
                    check("commit_drd", data_readdata, mon_e.drd);
                    check("commit_cycle", 32'(cyc_now - start_cyc + 1), 32'(mon_e.rel));
                end
            end
        end
    end

    task automatic start_instr(input logic [31:0] ia, input logic [31:0] fw, input logic dr,
                               input logic dw, input logic [31:0] da, input logic [3:0] be,
                               input logic [31:0] wd, input logic [31:0] ld,
                               input int fwt, input int dwt);
        @(negedge clk);
        instr_address = ia; fetch_word = fw;
        data_read = dr; data_write = dw; data_address = da;
        byte_enable = be; data_writedata = wd; load_word = ld;
        fetch_wait = fwt; data_wait = dwt;
        start_cyc = cyc_now;
        cpu_active = 1'b1;
    endtask

    task automatic wait_commit(input string name);
        bit seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (cpu_clk_enable) seen = 1;
        end
        cpu_active = 1'b0;
        if (!seen) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no commit within 100 cycles", name);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;
        bit activity;
        reset = 1'b1; cpu_active = 1'b0; instr_read = 1'b1;
        instr_address = '0; data_address = '0; data_read = 1'b0; data_write = 1'b0;
        data_writedata = '0; byte_enable = '0;
        repeat (2) @(negedge clk);
        check("reset_outputs", {31'b0, |{instr_readdata, data_readdata, cpu_clk_enable, mem_address,
              mem_read, mem_write, mem_writedata, mem_byteenable, bus_error, proto_error,
              instr_retired}}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // ALU instruction, zero-wait memory
        push_bus(0, 32'h0000_0400, 4'hF, 32'h0);
        push_commit(32'h0085_1021, 32'h0, 4);
        start_instr(32'h0000_0400, 32'h0085_1021, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0, 0, 0);
        wait_commit("alu");
        @(negedge clk);
        check("retired_after_alu", instr_retired, 32'd1);

        // Load with two wait cycles in DATA
        push_bus(0, 32'h0000_0404, 4'hF, 32'h0);
        push_bus(0, 32'h0000_1004, 4'hF, 32'h0);
        push_commit(32'h8C43_0004, 32'hDEAD_BEEF, 7);
        start_instr(32'h0000_0404, 32'h8C43_0004, 1, 0, 32'h0000_1004, 4'hF, 32'h0,
                    32'hDEAD_BEEF, 0, 2);
        wait_commit("load");

        // Store with unaligned address and upper byte lanes
        push_bus(0, 32'h0000_0408, 4'hF, 32'h0);
        push_bus(1, 32'h0000_2004, 4'b1100, 32'h1234_5678);
        push_commit(32'hAC45_0000, 32'hDEAD_BEEF, 5);
        start_instr(32'h0000_0408, 32'hAC45_0000, 0, 1, 32'h0000_2006, 4'b1100,
                    32'h1234_5678, 32'h0, 0, 0);
        wait_commit("store");

        // Read and write both requested: one write, load data untouched
        push_bus(0, 32'h0000_040C, 4'hF, 32'h0);
        push_bus(1, 32'h0000_3000, 4'hF, 32'hAABB_CCDD);
        push_commit(32'h0123_4567, 32'hDEAD_BEEF, 5);
        start_instr(32'h0000_040C, 32'h0123_4567, 1, 1, 32'h0000_3000, 4'hF,
                    32'hAABB_CCDD, 32'h5555_5555, 0, 0);
        wait_commit("proto");
        @(negedge clk);
        check("proto_error_set", {31'b0, proto_error}, 32'd1);
        check("bus_error_clear", {31'b0, bus_error}, 32'd0);

        // TIMEOUT-1 fetch wait cycles then release: normal completion; unaligned fetch address
        push_bus(0, 32'h0000_0410, 4'hF, 32'h0);
        push_commit(32'h0000_0020, 32'hDEAD_BEEF, 19);
        start_instr(32'h0000_0412, 32'h0000_0020, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0,
                    TIMEOUT - 1, 0);
        wait_commit("fetch_wait_15");
        @(negedge clk);
        check("retired_after_5", instr_retired, 32'd5);
        check("bus_error_after_15", {31'b0, bus_error}, 32'd0);

        // Reset mid-DATA while waitrequest is high
        push_bus(0, 32'h0000_0414, 4'hF, 32'h0);
        start_instr(32'h0000_0414, 32'hAC46_0008, 0, 1, 32'h0000_5008, 4'hF,
                    32'hCAFE_F00D, 32'h0, 0, 10);
        seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (mem_write) seen = 1;
        end
        check("store_started", {31'b0, seen}, 32'd1);
        reset = 1'b1;
        cpu_active = 1'b0;
        #1;
        check("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check("rst_retired", instr_retired, 32'd0);
        check("rst_instr_rd", instr_readdata, 32'd0);
        check("rst_data_rd", data_readdata, 32'd0);
        check("rst_mem_addr", mem_address, 32'd0);
        check("rst_flags", {30'b0, proto_error, bus_error}, 32'd0);
        check("queue_at_reset", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Fetch stalled for exactly TIMEOUT cycles: bus error, absorbing
        start_instr(32'h0000_0500, 32'h0000_0000, 0, 0, 32'h0, 4'hF, 32'h0, 32'h0, TIMEOUT, 0);
        repeat (TIMEOUT) @(negedge clk);
        check("fetch_last_wait_read", {31'b0, mem_read}, 32'd1);
        check("fetch_last_wait_berr", {31'b0, bus_error}, 32'd0);
        @(negedge clk);
        check("timeout_read_off", {31'b0, mem_read}, 32'd0);
        check("timeout_berr", {31'b0, bus_error}, 32'd1);
        check("timeout_retired", instr_retired, 32'd0);
        activity = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (mem_read || mem_write || cpu_clk_enable) activity = 1;
        end
        check("error_quiet", {31'b0, activity}, 32'd0);
        check("error_sticky", {31'b0, bus_error}, 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
